laser_echo_tester: RTL
======================

# laser_echo_tester

Stop-and-wait link tester for the far end of a laser echo link. It generates a pseudo-random byte stream, hands each byte to the laser transmitter, and waits for the same byte to come back from the laser receiver. It compares each returned byte and reports error and timeout counts. It sits between `LaserTransmitter`/`LaserReceiver` and the board's hex/LED status logic, opposite a node running in echo mode.

## Interface
- `SEED`, 8'h01: initial LFSR value; 8'h00 is replaced by 8'h01.
- `NUM_BYTES`, 16'd256: bytes per test run; must be ≥1.
- `TIMEOUT`, 16'd50000: cycles allowed per byte, from SEND until the echo arrives.
- `clock` input 1: system clock; single clock domain.
- `reset_n` input 1: synchronous, active-low reset.
- `start` input 1: level or pulse; begins a run when the block is not busy.
- `tx_done` input 1: one-cycle pulse from the transmitter when the byte has been fully sent.
- `data_valid` input 1: one-cycle pulse from the receiver; `data_in` is valid in that cycle.
- `data_in` input 8: received byte.
- `data_transmit` output 8: byte to send; held stable from SEND until `tx_done`.
- `data_ready` output 1: one-cycle request to the transmitter.
- `busy` output 1: run in progress.
- `pass` output 1: run finished with `err_count`==0.
- `fail` output 1: run finished with `err_count`≠0.
- `err_count` output 16: mismatches plus timeouts; saturates at 16'hFFFF.
- `timeout_count` output 16: timeouts only; saturates at 16'hFFFF.
- `byte_count` output 16: bytes completed in the current or last run.
- `last_rx` output 8: last byte accepted from the receiver, for hex display.

## Operation
- States: IDLE, SEND, WAIT_TX, WAIT_ECHO, DONE.
- IDLE → SEND on `start`. Entering SEND loads `lfsr`=SEED and clears `err_count`, `timeout_count`, `byte_count`, `pass` and `fail`.
- SEND:
  - `data_ready`=1 for exactly this cycle.
  - `data_transmit`=`lfsr`.
  - Clears the per-byte timer.
  - Goes to WAIT_TX.
- WAIT_TX:
  - `tx_done` → WAIT_ECHO.
  - `data_valid` in this state is ignored; `last_rx` is not updated.
- WAIT_ECHO, on `data_valid`:
  - `last_rx`←`data_in`.
  - If `data_in`≠`lfsr`, `err_count`+1.
  - Then advance.
- Timeout: the timer runs in WAIT_TX and WAIT_ECHO. When timer==TIMEOUT−1 and no `data_valid` is accepted in that cycle:
  - `err_count`+1 and `timeout_count`+1.
  - Then advance.
  - This applies from either state.
- Advance:
  - `byte_count`+1.
  - `lfsr` ← {`lfsr[6:0]`, `lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]`}.
  - If the new `byte_count`==NUM_BYTES → DONE, else → SEND.
- DONE:
  - `pass`/`fail` set and held.
  - `start` → SEND, which begins a new run and clears `pass`/`fail`.
- `start` while `busy` is ignored.
- `busy`=1 in SEND, WAIT_TX and WAIT_ECHO.
- Counters saturate; no wrap-around.
- The LFSR sequence from 8'h01 is 01, 02, 04, 08, 11, 23, …

## Timing
- Reset (`reset_n`=0 at a `clock` edge):
  - State←IDLE.
  - All outputs 0: `data_transmit`=8'h00, `data_ready`=0, counters 0, `pass`=`fail`=`busy`=0, `last_rx`=8'h00.
  - Reset mid-run aborts immediately; no further `data_ready`.
- `start` sampled at cycle N → SEND at N+1. `data_ready` and `busy` are high at N+1.
- All outputs are registered except `data_ready` and `busy`, which decode from state.
- `data_valid` and timeout in the same cycle: the echo wins; the byte is compared and no timeout is counted.
- `tx_done` and the timeout cycle coincide in WAIT_TX: the timeout wins.
- Minimum period per byte: SEND, one WAIT_TX cycle, one WAIT_ECHO cycle = 3 cycles.

## Test plan
- Clean echo, NUM_BYTES=4: echo each `data_transmit` 5 cycles after `tx_done`. Expect bytes 01,02,04,08, then `pass`=1, `err_count`=0, `byte_count`=4.
- Corrupt third echo (send 8'hFF instead of 8'h04). Expect `fail`=1, `err_count`=1, `timeout_count`=0, `last_rx`=8'h08 at DONE.
- No echo for byte 2, TIMEOUT=16. Expect the next `data_ready` exactly 16 cycles after byte 2's SEND, `err_count`=`timeout_count`=1.
- `data_valid` in WAIT_TX and a `start` pulse while busy: both ignored; byte sequence and counters unchanged.
- `reset_n` low during WAIT_ECHO: next cycle everything is 0 and `busy`=0; a later `start` restarts from SEED with counters 0.
- TIMEOUT=4, never echo, NUM_BYTES=3: expect `err_count`=3, `timeout_count`=3, `fail`=1; `data_ready` pulses 4 cycles apart.

Source files
------------

// File: rtl/laser_echo_tester.sv
// laser_echo_tester: stop-and-wait LFSR byte tester that checks each byte echoed back over the laser link.
module laser_echo_tester #(
   parameter logic [7:0]  SEED      = 8'h01,
   parameter logic [15:0] NUM_BYTES = 16'd256,
   parameter logic [15:0] TIMEOUT   = 16'd50000
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   input  logic        tx_done,
   input  logic        data_valid,
   input  logic [7:0]  data_in,
   output logic [7:0]  data_transmit,
   output logic        data_ready,
   output logic        busy,
   output logic        pass,
   output logic        fail,
   output logic [15:0] err_count,
   output logic [15:0] timeout_count,
   output logic [15:0] byte_count,
   output logic [7:0]  last_rx
);
   typedef enum logic [2:0] {IDLE, SEND, WAIT_TX, WAIT_ECHO, DONE} state_t;
   localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
   state_t state, state_nx;
   logic [7:0] lfsr;
   logic [15:0] timer, err_nx;
   logic accept, timeout_hit, miss, advance, last_byte, launch, waiting;
   assign waiting     = (state == WAIT_TX) || (state == WAIT_ECHO);
   assign launch      = ((state == IDLE) || (state == DONE)) && start;
   assign accept      = (state == WAIT_ECHO) && data_valid;
   // an echo landing in the timeout cycle takes priority over the timeout
   assign timeout_hit = waiting && !accept && (timer == TIMEOUT - 16'd1);
   assign miss        = accept && (data_in != lfsr);
   assign advance     = accept || timeout_hit;
   assign last_byte   = (byte_count + 16'd1) == NUM_BYTES;
   assign err_nx      = (miss || timeout_hit) ? err_count + {15'd0, ~&err_count} : err_count;
   assign data_transmit = lfsr;
   always_ff @(posedge clock) begin
      if (!reset_n) state <= IDLE;
      else state <= state_nx;
   end
   always_comb begin
      state_nx = state;
      case (state)
         IDLE, DONE: state_nx = start ? SEND : state;
         SEND:       state_nx = WAIT_TX;
         WAIT_TX:    state_nx = timeout_hit ? (last_byte ? DONE : SEND) : (tx_done ? WAIT_ECHO : WAIT_TX);
         WAIT_ECHO:  state_nx = advance ? (last_byte ? DONE : SEND) : WAIT_ECHO;
         default:    state_nx = IDLE;
      endcase
   end
   always_comb begin
      data_ready = state == SEND;
      busy       = (state == SEND) || waiting;
   end
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         lfsr          <= 8'h00;
         timer         <= 16'd0;
         err_count     <= 16'd0;
         timeout_count <= 16'd0;
         byte_count    <= 16'd0;
         last_rx       <= 8'h00;
         pass          <= 1'b0;
         fail          <= 1'b0;
      end else begin
         if (launch) begin
            lfsr          <= SEED_EFF;
            err_count     <= 16'd0;
            timeout_count <= 16'd0;
            byte_count    <= 16'd0;
            pass          <= 1'b0;
            fail          <= 1'b0;
         end
         // timer holds cycles elapsed since SEND
         if (state == SEND) timer <= 16'd1;
         else if (waiting) timer <= timer + 16'd1;
         if (accept) last_rx <= data_in;
         if (waiting) err_count <= err_nx;
         if (timeout_hit) timeout_count <= timeout_count + {15'd0, ~&timeout_count};
         if (advance) begin
            byte_count <= byte_count + 16'd1;
            lfsr       <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            if (last_byte) begin
               pass <= err_nx == 16'd0;
               fail <= err_nx != 16'd0;
            end
         end
      end
   end
endmodule
